// File: rtl/cam_frame_writer.sv
// Camera RGB565 byte stream to 3-bit RGB frame buffer writer.
// Aligns to vsync/href framing, generates linear addresses and flags malformed lines.
module cam_frame_writer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              clk_25,
  input  logic              rst,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic              cam_valid,
  input  logic [7:0]        cam_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [2:0]        wr_data,
  output logic              frame_done,
  output logic              err
);

  localparam int CW = $clog2(H_ACTIVE + 1);
  localparam int RW = $clog2(V_ACTIVE + 1);
  localparam logic [CW-1:0]     H_MAX  = CW'(H_ACTIVE);
  localparam logic [RW-1:0]     V_MAX  = RW'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_ACTIVE);

  typedef enum logic [1:0] {SYNC, FRAME_GAP, LINE_WAIT, LINE} state_t;

  state_t            state_q;
  logic [CW-1:0]     col_q;
  logic [RW-1:0]     row_q;
  logic [ADDR_W-1:0] row_base_q;
  logic              phase_q;
  logic [7:0]        hi_q;
  logic              take_d;
  logic              in_frame_d;

  // The cycle href is first seen high already belongs to the line, so its byte is kept.
  assign take_d     = cam_href && cam_valid && !cam_vsync &&
                      (state_q == LINE || state_q == LINE_WAIT);
  assign in_frame_d = (col_q < H_MAX) && (row_q < V_MAX);

  always_ff @(posedge clk_25) begin
    if (rst) begin
      state_q    <= SYNC;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      phase_q    <= 1'b0;
      hi_q       <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      case (state_q)
        SYNC: if (cam_vsync) state_q <= FRAME_GAP;
        FRAME_GAP: begin
          col_q      <= '0;
          row_q      <= '0;
          row_base_q <= '0;
          phase_q    <= 1'b0;
          if (!cam_vsync) state_q <= LINE_WAIT;
        end
        LINE_WAIT: begin
          if (cam_vsync) begin
            state_q    <= FRAME_GAP;
            frame_done <= (row_q != '0);
          end else if (cam_href) begin
            state_q <= LINE;
          end
        end
        LINE: begin
          if (cam_vsync) begin
            state_q    <= FRAME_GAP;
            frame_done <= (row_q != '0);
            err        <= 1'b1;
            phase_q    <= 1'b0;
          end else if (!cam_href) begin
            state_q <= LINE_WAIT;
            if (phase_q || col_q != H_MAX) err <= 1'b1;
            // Row saturates so surplus lines can never wrap back into the buffer.
            if (row_q < V_MAX) begin
              row_q      <= row_q + 1'b1;
              row_base_q <= row_base_q + H_STEP;
            end
            col_q   <= '0;
            phase_q <= 1'b0;
          end
        end
        default: state_q <= SYNC;
      endcase

      if (take_d) begin
        phase_q <= ~phase_q;
        if (!phase_q) begin
          hi_q <= cam_data;
        end else begin
          if (col_q < H_MAX) col_q <= col_q + 1'b1;
          if (in_frame_d) begin
            wr_en   <= 1'b1;
            wr_addr <= row_base_q + ADDR_W'(col_q);
            wr_data <= {hi_q[7], hi_q[2], cam_data[4]};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_frame_writer.sv
// Scoreboard bench for cam_frame_writer on a reduced 16x8 frame.
// Expected writes are queued as pixels are driven and popped by the write monitor.
module tb_cam_frame_writer;
  localparam int H  = 16;
  localparam int V  = 8;
  localparam int AW = 19;

  logic          clk_25 = 1'b0;
  logic          rst = 1'b1;
  logic          cam_vsync = 1'b0, cam_href = 1'b0, cam_valid = 1'b0;
  logic [7:0]    cam_data = '0;
  logic          wr_en, frame_done, err;
  logic [AW-1:0] wr_addr;
  logic [2:0]    wr_data;

  logic [AW+2:0] sb[$];
  int            wr_times[$];
  int n_cmp = 0, n_err = 0;
  int cyc = 0, fd_cnt = 0, wr_cnt = 0;
  logic fd_prev = 1'b0;

  cam_frame_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .clk_25(clk_25), .rst(rst), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_valid(cam_valid), .cam_data(cam_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .frame_done(frame_done), .err(err)
  );

  always #20 clk_25 = ~clk_25;

  // Write / frame_done monitor, sampled 1 time unit after the active edge.
  always @(posedge clk_25) begin
    logic [AW+2:0] exp_w;
    #1;
    cyc++;
    if (frame_done) begin
      fd_cnt++;
      n_cmp++;
      if (fd_prev !== 1'b0) begin
        n_err++;
        $display("FAIL frame_done_width: got two-cycle pulse, required one cycle");
      end
    end
    fd_prev = frame_done;
    if (wr_en === 1'b1) begin
      wr_cnt++;
      wr_times.push_back(cyc);
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: addr=%0d data=%b, required no write", wr_addr, wr_data);
      end else begin
        exp_w = sb.pop_front();
        if ({wr_addr, wr_data} !== exp_w) begin
          n_err++;
          $display("FAIL write: addr=%0d data=%b, required addr=%0d data=%b",
                   wr_addr, wr_data, exp_w[AW+2:3], exp_w[2:0]);
        end
      end
    end
  end

  task automatic do_reset;
    @(negedge clk_25);
    rst = 1'b1; cam_vsync = 1'b0; cam_href = 1'b0; cam_valid = 1'b0; cam_data = '0;
    repeat (2) @(negedge clk_25);
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit slow);
    @(negedge clk_25);
    cam_valid = 1'b1; cam_data = b;
    if (slow) begin
      @(negedge clk_25);
      cam_valid = 1'b0;
    end
  endtask

  // row >= V means the pixel is outside the buffer (or not expected), so nothing is queued.
  task automatic send_pix(input logic [7:0] hi, input logic [7:0] lo, input int row,
                          input int col, input bit slow);
    logic [AW-1:0] a;
    send_byte(hi, slow);
    if (col < H && row < V) begin
      a = AW'(row * H + col);
      sb.push_back({a, hi[7], hi[2], lo[4]});
    end
    send_byte(lo, slow);
  endtask

  task automatic line_begin;
    @(negedge clk_25);
    cam_valid = 1'b0; cam_href = 1'b1;
  endtask

  task automatic line_end;
    @(negedge clk_25);
    cam_valid = 1'b0; cam_href = 1'b0;
    @(negedge clk_25);
  endtask

  task automatic send_line(input int row, input int npix, input logic [7:0] hi,
                           input logic [7:0] lo, input bit slow, input bit half);
    line_begin();
    for (int p = 0; p < npix; p++) send_pix(hi, lo, row, p, slow);
    if (half) send_byte(hi, 1'b0);
    line_end();
  endtask

  task automatic frame_start;
    @(negedge clk_25);
    cam_vsync = 1'b1;
    repeat (2) @(negedge clk_25);
    cam_vsync = 1'b0;
    repeat (2) @(negedge clk_25);
  endtask

  task automatic frame_end;
    @(negedge clk_25);
    cam_vsync = 1'b1;
    repeat (3) @(negedge clk_25);
  endtask

  task automatic test_reset;
    do_reset();
    n_cmp += 5;
    if (wr_en !== 1'b0)      begin n_err++; $display("FAIL reset_wr_en: got %b, required 0", wr_en); end
    if (wr_addr !== '0)      begin n_err++; $display("FAIL reset_wr_addr: got %0d, required 0", wr_addr); end
    if (wr_data !== 3'b000)  begin n_err++; $display("FAIL reset_wr_data: got %b, required 000", wr_data); end
    if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done: got %b, required 0", frame_done); end
    if (err !== 1'b0)        begin n_err++; $display("FAIL reset_err: got %b, required 0", err); end
  endtask

  task automatic test_full_frame;
    int fd0 = fd_cnt, w0 = wr_cnt;
    frame_start();
    for (int r = 0; r < V; r++) send_line(r, H, 8'h80, 8'h10, 1'b0, 1'b0);
    frame_end();
    n_cmp += 4;
    if (fd_cnt - fd0 != 1) begin n_err++; $display("FAIL full_frame_done: got %0d pulses, required 1", fd_cnt - fd0); end
    if (err !== 1'b0)      begin n_err++; $display("FAIL full_frame_err: got %b, required 0", err); end
    if (wr_cnt - w0 != H*V) begin n_err++; $display("FAIL full_frame_writes: got %0d, required %0d", wr_cnt - w0, H*V); end
    if (sb.size() != 0)    begin n_err++; $display("FAIL full_frame_missing: %0d writes outstanding, required 0", sb.size()); end
  endtask

  task automatic test_slow_valid;
    int t0;
    frame_start();
    t0 = wr_times.size();
    send_line(0, H, 8'h04, 8'h00, 1'b1, 1'b0);
    for (int i = t0 + 1; i < wr_times.size(); i++) begin
      n_cmp++;
      if (wr_times[i] - wr_times[i-1] != 4) begin
        n_err++;
        $display("FAIL slow_spacing: got %0d cycles, required 4", wr_times[i] - wr_times[i-1]);
      end
    end
    for (int r = 1; r < V; r++) send_line(r, H, 8'hFF, 8'hEF, 1'b0, 1'b0);
    frame_end();
    n_cmp += 3;
    if (wr_times.size() - t0 != H*V) begin n_err++; $display("FAIL slow_writes: got %0d, required %0d", wr_times.size() - t0, H*V); end
    if (err !== 1'b0)   begin n_err++; $display("FAIL slow_err: got %b, required 0", err); end
    if (sb.size() != 0) begin n_err++; $display("FAIL slow_missing: %0d outstanding, required 0", sb.size()); end
  endtask

  task automatic test_long_short;
    do_reset();
    frame_start();
    send_line(0, H + 1, 8'h84, 8'h10, 1'b0, 1'b0);
    n_cmp++;
    if (err !== 1'b0) begin n_err++; $display("FAIL long_line_err: got %b, required 0", err); end
    send_line(1, H - 1, 8'h00, 8'h10, 1'b0, 1'b0);
    n_cmp++;
    if (err !== 1'b1) begin n_err++; $display("FAIL short_line_err: got %b, required 1", err); end
    frame_end();
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL long_short_missing: %0d outstanding, required 0", sb.size()); end
  endtask

  task automatic test_odd_bytes;
    int w0;
    do_reset();
    w0 = wr_cnt;
    frame_start();
    send_line(0, H, 8'h7B, 8'hEF, 1'b0, 1'b1);
    n_cmp++;
    if (err !== 1'b1) begin n_err++; $display("FAIL odd_err: got %b, required 1", err); end
    send_line(1, H, 8'h80, 8'h00, 1'b0, 1'b0);
    frame_end();
    n_cmp += 2;
    if (wr_cnt - w0 != 2*H) begin n_err++; $display("FAIL odd_writes: got %0d, required %0d", wr_cnt - w0, 2*H); end
    if (sb.size() != 0)     begin n_err++; $display("FAIL odd_missing: %0d outstanding, required 0", sb.size()); end
  endtask

  task automatic test_reset_mid_line;
    int w0;
    do_reset();
    w0 = wr_cnt;
    frame_start();
    line_begin();
    for (int p = 0; p < 3; p++) send_pix(8'h84, 8'h10, 0, p, 1'b0);
    send_byte(8'h84, 1'b0);
    @(negedge clk_25);
    cam_data = 8'h10; rst = 1'b1;
    @(negedge clk_25);
    n_cmp += 2;
    if (wr_en !== 1'b0) begin n_err++; $display("FAIL midreset_wr_en: got %b, required 0", wr_en); end
    if (wr_addr !== '0) begin n_err++; $display("FAIL midreset_wr_addr: got %0d, required 0", wr_addr); end
    for (int i = 0; i < 6; i++) send_byte(8'hFF, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) send_byte(8'hFF, 1'b0);
    line_end();
    send_line(V, H, 8'hFF, 8'hFF, 1'b0, 1'b0);
    n_cmp++;
    if (wr_cnt - w0 != 3) begin n_err++; $display("FAIL midreset_writes: got %0d, required 3", wr_cnt - w0); end
    frame_start();
    send_line(0, H, 8'h04, 8'h10, 1'b0, 1'b0);
    frame_end();
    n_cmp += 2;
    if (sb.size() != 0) begin n_err++; $display("FAIL midreset_missing: %0d outstanding, required 0", sb.size()); end
    if (err !== 1'b0)   begin n_err++; $display("FAIL midreset_err: got %b, required 0", err); end
  endtask

  task automatic test_vsync_mid_line;
    int fd0;
    do_reset();
    fd0 = fd_cnt;
    frame_start();
    for (int r = 0; r < 5; r++) send_line(r, H, 8'h80, 8'h10, 1'b0, 1'b0);
    line_begin();
    for (int p = 0; p < 3; p++) send_pix(8'h04, 8'h10, 5, p, 1'b0);
    send_byte(8'h80, 1'b0);
    @(negedge clk_25);
    cam_valid = 1'b0; cam_vsync = 1'b1;
    repeat (3) @(negedge clk_25);
    n_cmp += 2;
    if (err !== 1'b1)      begin n_err++; $display("FAIL abort_err: got %b, required 1", err); end
    if (fd_cnt - fd0 != 1) begin n_err++; $display("FAIL abort_frame_done: got %0d pulses, required 1", fd_cnt - fd0); end
    cam_href = 1'b0;
    @(negedge clk_25);
    cam_vsync = 1'b0;
    repeat (2) @(negedge clk_25);
    send_line(0, H, 8'h80, 8'h00, 1'b0, 1'b0);
    frame_end();
    n_cmp += 2;
    if (sb.size() != 0)    begin n_err++; $display("FAIL abort_missing: %0d outstanding, required 0", sb.size()); end
    if (fd_cnt - fd0 != 2) begin n_err++; $display("FAIL abort_next_frame: got %0d pulses, required 2", fd_cnt - fd0); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_slow_valid();
    test_long_short();
    test_odd_bytes();
    test_reset_mid_line();
    test_vsync_mid_line();
    repeat (4) @(negedge clk_25);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
